// File: rtl/cpu_decode_control.sv
// rtl/cpu_decode_control.sv - LEGv8 main/ALU control decode with offset-magnitude adder (optional LOGIC_OPS_EN)

module cpu_offset_addsub #(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              ovf
);

    logic [DATA_W:0]   carry;
    logic [DATA_W-1:0] b_eff;

    // Two's-complement subtract: invert B and inject the +1 as carry-in.
    always_comb begin
        carry    = '0;
        carry[0] = sub;
        b_eff    = b ^ {DATA_W{sub}};
        sum      = '0;
        for (int i = 0; i < DATA_W; i++) begin
            sum[i]       = a[i] ^ b_eff[i] ^ carry[i];
            carry[i + 1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
        end
    end

    assign cout = carry[DATA_W];
    assign ovf  = carry[DATA_W] ^ carry[DATA_W-1];

endmodule

module cpu_decode_control #(
    parameter int DATA_W = 64,
    parameter int OFFS_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       opcode,
    input  logic [OFFS_W-1:0] daddr9,
    output logic              reg2loc,
    output logic              alu_src,
    output logic              imm,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch,
    output logic              uncond_br,
    output logic              branch_reg,
    output logic              branch_link,
    output logic              alu_sh,
    output logic              shift_dirn,
    output logic              set_flags,
    output logic              alu_on,
    output logic [2:0]        alu_cntrl,
    output logic [DATA_W-1:0] offset_mag,
    output logic              offset_neg,
    output logic              illegal_op
);

    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_BR   = 11'b11010110000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
`ifdef LOGIC_OPS_EN
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
`endif

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
`ifdef LOGIC_OPS_EN
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_ORR    = 3'b101;
    localparam logic [2:0] ALU_EOR    = 3'b110;
`endif

    typedef enum logic [3:0] {
        INS_NONE,
        INS_ADDI,
        INS_ADDS,
        INS_SUBS,
        INS_LDUR,
        INS_STUR,
        INS_BR,
        INS_LSL,
        INS_LSR,
        INS_BCOND,
        INS_CBZ,
        INS_B,
        INS_BL,
        INS_AND,
        INS_ORR,
        INS_EOR
    } ins_e;

    ins_e ins;

    logic [DATA_W-1:0] daddr_se;
    logic              add_cout;
    logic              add_ovf;
    logic              unused_add_flags;

    logic       raw_reg_write;
    logic       raw_mem_read;
    logic       raw_mem_write;
    logic       raw_branch;
    logic       raw_set_flags;
    logic [2:0] raw_alu_cntrl;

    // Full 11-bit opcodes take priority; shorter prefixes are only tried on a miss.
    always_comb begin
        ins = INS_NONE;
        case (opcode)
            OP_ADDS: ins = INS_ADDS;
            OP_SUBS: ins = INS_SUBS;
            OP_LDUR: ins = INS_LDUR;
            OP_STUR: ins = INS_STUR;
            OP_BR:   ins = INS_BR;
            OP_LSL:  ins = INS_LSL;
            OP_LSR:  ins = INS_LSR;
`ifdef LOGIC_OPS_EN
            OP_AND:  ins = INS_AND;
            OP_ORR:  ins = INS_ORR;
            OP_EOR:  ins = INS_EOR;
`endif
            default: begin
                if (opcode[10:1] == 10'b1001000100) begin
                    ins = INS_ADDI;
                end else if (opcode[10:3] == 8'b01010100) begin
                    ins = INS_BCOND;
                end else if (opcode[10:3] == 8'b10110100) begin
                    ins = INS_CBZ;
                end else if (opcode[10:5] == 6'b000101) begin
                    ins = INS_B;
                end else if (opcode[10:5] == 6'b100101) begin
                    ins = INS_BL;
                end else begin
                    ins = INS_NONE;
                end
            end
        endcase
    end

    always_comb begin
        reg2loc       = 1'b0;
        alu_src       = 1'b0;
        imm           = 1'b0;
        mem_to_reg    = 1'b0;
        raw_reg_write = 1'b0;
        raw_mem_read  = 1'b0;
        raw_mem_write = 1'b0;
        raw_branch    = 1'b0;
        uncond_br     = 1'b0;
        branch_reg    = 1'b0;
        branch_link   = 1'b0;
        alu_sh        = 1'b0;
        shift_dirn    = 1'b0;
        raw_set_flags = 1'b0;
        alu_on        = 1'b0;
        raw_alu_cntrl = ALU_PASS_B;
        case (ins)
            INS_ADDI: begin
                alu_src       = 1'b1;
                imm           = 1'b1;
                raw_reg_write = 1'b1;
                alu_on        = 1'b1;
                raw_alu_cntrl = ALU_ADD;
            end
            INS_ADDS, INS_SUBS: begin
                reg2loc       = 1'b1;
                raw_reg_write = 1'b1;
                raw_set_flags = 1'b1;
                alu_on        = 1'b1;
                raw_alu_cntrl = (ins == INS_SUBS) ? ALU_SUB : ALU_ADD;
            end
            INS_LDUR: begin
                alu_src       = 1'b1;
                mem_to_reg    = 1'b1;
                raw_reg_write = 1'b1;
                raw_mem_read  = 1'b1;
                alu_on        = 1'b1;
                raw_alu_cntrl = offset_neg ? ALU_SUB : ALU_ADD;
            end
            INS_STUR: begin
                alu_src       = 1'b1;
                raw_mem_write = 1'b1;
                alu_on        = 1'b1;
                raw_alu_cntrl = offset_neg ? ALU_SUB : ALU_ADD;
            end
            INS_CBZ: begin
                raw_branch    = 1'b1;
                alu_on        = 1'b1;
                raw_alu_cntrl = ALU_PASS_B;
            end
            INS_BCOND: begin
                raw_branch = 1'b1;
            end
            INS_B: begin
                raw_branch = 1'b1;
                uncond_br  = 1'b1;
            end
            INS_BL: begin
                raw_branch    = 1'b1;
                uncond_br     = 1'b1;
                branch_link   = 1'b1;
                raw_reg_write = 1'b1;
            end
            INS_BR: begin
                raw_branch = 1'b1;
                branch_reg = 1'b1;
            end
            INS_LSL, INS_LSR: begin
                alu_sh        = 1'b1;
                raw_reg_write = 1'b1;
                shift_dirn    = (ins == INS_LSR);
            end
`ifdef LOGIC_OPS_EN
            INS_AND, INS_ORR, INS_EOR: begin
                reg2loc       = 1'b1;
                raw_reg_write = 1'b1;
                alu_on        = 1'b1;
                raw_alu_cntrl = (ins == INS_AND) ? ALU_AND :
                                (ins == INS_ORR) ? ALU_ORR : ALU_EOR;
            end
`endif
            default: ;
        endcase
    end

    // Reset suppresses every architecturally visible side effect.
    assign reg_write = raw_reg_write & ~rst;
    assign mem_read  = raw_mem_read  & ~rst;
    assign mem_write = raw_mem_write & ~rst;
    assign branch    = raw_branch    & ~rst;
    assign set_flags = raw_set_flags & ~rst;
    assign alu_cntrl = alu_on ? raw_alu_cntrl : ALU_PASS_B;

    assign offset_neg = daddr9[OFFS_W-1];
    assign daddr_se   = {{(DATA_W-OFFS_W){daddr9[OFFS_W-1]}}, daddr9};

    cpu_offset_addsub #(
        .DATA_W(DATA_W)
    ) u_offset_addsub (
        .a    ('0),
        .b    (daddr_se),
        .sub  (offset_neg),
        .sum  (offset_mag),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    assign unused_add_flags = add_cout ^ add_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_op <= 1'b0;
        end else if (ins == INS_NONE) begin
            illegal_op <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_decode_control.sv
// tb/tb_cpu_decode_control.sv - directed self-checking bench for cpu_decode_control

module tb_cpu_decode_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] opcode;
    logic [8:0]  daddr9;
    logic        reg2loc, alu_src, imm, mem_to_reg, reg_write, mem_read, mem_write;
    logic        branch, uncond_br, branch_reg, branch_link, alu_sh, shift_dirn;
    logic        set_flags, alu_on, offset_neg, illegal_op;
    logic [2:0]  alu_cntrl;
    logic [63:0] offset_mag;
    logic [17:0] ctrl;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cpu_decode_control dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .daddr9      (daddr9),
        .reg2loc     (reg2loc),
        .alu_src     (alu_src),
        .imm         (imm),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .branch      (branch),
        .uncond_br   (uncond_br),
        .branch_reg  (branch_reg),
        .branch_link (branch_link),
        .alu_sh      (alu_sh),
        .shift_dirn  (shift_dirn),
        .set_flags   (set_flags),
        .alu_on      (alu_on),
        .alu_cntrl   (alu_cntrl),
        .offset_mag  (offset_mag),
        .offset_neg  (offset_neg),
        .illegal_op  (illegal_op)
    );

    // r2l as imm m2r rw mr mw br ub brr bl sh dir sf on | alu_cntrl
    assign ctrl = {reg2loc, alu_src, imm, mem_to_reg, reg_write, mem_read, mem_write,
                   branch, uncond_br, branch_reg, branch_link, alu_sh, shift_dirn,
                   set_flags, alu_on, alu_cntrl};

    task automatic apply(input logic [10:0] op, input logic [8:0] d);
        @(negedge clk);
        opcode = op;
        daddr9 = d;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        apply(11'b00000000000, 9'h000);
        @(posedge clk); #1;
        tests_run++;
        if (illegal_op !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wins_illegal: illegal_op=%b expected 0", illegal_op);
        end
        tests_run++;
        if (ctrl !== 18'b0) begin
            tests_failed++;
            $display("FAIL reset_nop_ctrl: ctrl=%b expected %b", ctrl, 18'b0);
        end
        apply(11'b10101011000, 9'h000);
        tests_run++;
        if (ctrl !== 18'b1_0_0_0_0_0_0_0_0_0_0_0_0_0_1_010) begin
            tests_failed++;
            $display("FAIL reset_gates_adds: ctrl=%b expected %b", ctrl, 18'b1_0_0_0_0_0_0_0_0_0_0_0_0_0_1_010);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_arith;
        apply(11'b10101011000, 9'h000);
        tests_run++;
        if (ctrl !== 18'b1_0_0_0_1_0_0_0_0_0_0_0_0_1_1_010) begin
            tests_failed++;
            $display("FAIL adds: ctrl=%b expected %b", ctrl, 18'b1_0_0_0_1_0_0_0_0_0_0_0_0_1_1_010);
        end
        apply(11'b11101011000, 9'h000);
        tests_run++;
        if (ctrl !== 18'b1_0_0_0_1_0_0_0_0_0_0_0_0_1_1_011) begin
            tests_failed++;
            $display("FAIL subs: ctrl=%b expected %b", ctrl, 18'b1_0_0_0_1_0_0_0_0_0_0_0_0_1_1_011);
        end
        apply(11'b10010001001, 9'h1FF);
        tests_run++;
        if (ctrl !== 18'b0_1_1_0_1_0_0_0_0_0_0_0_0_0_1_010) begin
            tests_failed++;
            $display("FAIL addi: ctrl=%b expected %b", ctrl, 18'b0_1_1_0_1_0_0_0_0_0_0_0_0_0_1_010);
        end
    endtask

    task automatic test_mem_offset;
        apply(11'b11111000010, 9'h1F8);
        tests_run++;
        if (ctrl !== 18'b0_1_0_1_1_1_0_0_0_0_0_0_0_0_1_011) begin
            tests_failed++;
            $display("FAIL ldur_neg_ctrl: ctrl=%b expected %b", ctrl, 18'b0_1_0_1_1_1_0_0_0_0_0_0_0_0_1_011);
        end
        tests_run++;
        if (offset_mag !== 64'd8 || offset_neg !== 1'b1) begin
            tests_failed++;
            $display("FAIL ldur_neg_offset: mag=%0d neg=%b expected 8 1", offset_mag, offset_neg);
        end
        apply(11'b11111000010, 9'h010);
        tests_run++;
        if (offset_mag !== 64'd16 || offset_neg !== 1'b0 || alu_cntrl !== 3'b010) begin
            tests_failed++;
            $display("FAIL ldur_pos: mag=%0d neg=%b op=%b expected 16 0 010", offset_mag, offset_neg, alu_cntrl);
        end
        apply(11'b11111000010, 9'h100);
        tests_run++;
        if (offset_mag !== 64'd256 || offset_neg !== 1'b1 || alu_cntrl !== 3'b011) begin
            tests_failed++;
            $display("FAIL ldur_min: mag=%0d neg=%b op=%b expected 256 1 011", offset_mag, offset_neg, alu_cntrl);
        end
        apply(11'b11111000000, 9'h000);
        tests_run++;
        if (offset_mag !== 64'd0 || ctrl !== 18'b0_1_0_0_0_0_1_0_0_0_0_0_0_0_1_010) begin
            tests_failed++;
            $display("FAIL stur_zero: mag=%0d ctrl=%b expected 0 %b", offset_mag, ctrl, 18'b0_1_0_0_0_0_1_0_0_0_0_0_0_0_1_010);
        end
        apply(11'b11111000000, 9'h0FF);
        tests_run++;
        if (offset_mag !== 64'd255 || offset_neg !== 1'b0) begin
            tests_failed++;
            $display("FAIL stur_max: mag=%0d neg=%b expected 255 0", offset_mag, offset_neg);
        end
        apply(11'b11111000000, 9'h1FF);
        tests_run++;
        if (offset_mag !== 64'd1 || alu_cntrl !== 3'b011) begin
            tests_failed++;
            $display("FAIL stur_m1: mag=%0d op=%b expected 1 011", offset_mag, alu_cntrl);
        end
    endtask

    task automatic test_branch;
        apply(11'b10010100000, 9'h000);
        tests_run++;
        if (ctrl !== 18'b0_0_0_0_1_0_0_1_1_0_1_0_0_0_0_000) begin
            tests_failed++;
            $display("FAIL bl: ctrl=%b expected %b", ctrl, 18'b0_0_0_0_1_0_0_1_1_0_1_0_0_0_0_000);
        end
        apply(11'b10110100101, 9'h1F8);
        tests_run++;
        if (ctrl !== 18'b0_0_0_0_0_0_0_1_0_0_0_0_0_0_1_000) begin
            tests_failed++;
            $display("FAIL cbz: ctrl=%b expected %b", ctrl, 18'b0_0_0_0_0_0_0_1_0_0_0_0_0_0_1_000);
        end
        apply(11'b00010111111, 9'h000);
        tests_run++;
        if (ctrl !== 18'b0_0_0_0_0_0_0_1_1_0_0_0_0_0_0_000) begin
            tests_failed++;
            $display("FAIL b: ctrl=%b expected %b", ctrl, 18'b0_0_0_0_0_0_0_1_1_0_0_0_0_0_0_000);
        end
        apply(11'b01010100011, 9'h000);
        tests_run++;
        if (ctrl !== 18'b0_0_0_0_0_0_0_1_0_0_0_0_0_0_0_000) begin
            tests_failed++;
            $display("FAIL bcond: ctrl=%b expected %b", ctrl, 18'b0_0_0_0_0_0_0_1_0_0_0_0_0_0_0_000);
        end
        apply(11'b11010110000, 9'h000);
        tests_run++;
        if (ctrl !== 18'b0_0_0_0_0_0_0_1_0_1_0_0_0_0_0_000) begin
            tests_failed++;
            $display("FAIL br: ctrl=%b expected %b", ctrl, 18'b0_0_0_0_0_0_0_1_0_1_0_0_0_0_0_000);
        end
    endtask

    task automatic test_shift;
        apply(11'b11010011010, 9'h000);
        tests_run++;
        if (ctrl !== 18'b0_0_0_0_1_0_0_0_0_0_0_1_1_0_0_000) begin
            tests_failed++;
            $display("FAIL lsr: ctrl=%b expected %b", ctrl, 18'b0_0_0_0_1_0_0_0_0_0_0_1_1_0_0_000);
        end
        apply(11'b11010011011, 9'h000);
        tests_run++;
        if (ctrl !== 18'b0_0_0_0_1_0_0_0_0_0_0_1_0_0_0_000) begin
            tests_failed++;
            $display("FAIL lsl: ctrl=%b expected %b", ctrl, 18'b0_0_0_0_1_0_0_0_0_0_0_1_0_0_0_000);
        end
        @(posedge clk); #1;
        tests_run++;
        if (illegal_op !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_spurious_illegal: illegal_op=%b expected 0", illegal_op);
        end
    endtask

    task automatic test_logic_ops;
        apply(11'b10001010000, 9'h000);
`ifdef LOGIC_OPS_EN
        tests_run++;
        if (ctrl !== 18'b1_0_0_0_1_0_0_0_0_0_0_0_0_0_1_100) begin
            tests_failed++;
            $display("FAIL and_op: ctrl=%b expected %b", ctrl, 18'b1_0_0_0_1_0_0_0_0_0_0_0_0_0_1_100);
        end
        apply(11'b11001010000, 9'h000);
        tests_run++;
        if (ctrl !== 18'b1_0_0_0_1_0_0_0_0_0_0_0_0_0_1_110) begin
            tests_failed++;
            $display("FAIL eor_op: ctrl=%b expected %b", ctrl, 18'b1_0_0_0_1_0_0_0_0_0_0_0_0_0_1_110);
        end
        @(posedge clk); #1;
        tests_run++;
        if (illegal_op !== 1'b0) begin
            tests_failed++;
            $display("FAIL logic_legal: illegal_op=%b expected 0", illegal_op);
        end
`else
        tests_run++;
        if (ctrl !== 18'b0) begin
            tests_failed++;
            $display("FAIL and_nop: ctrl=%b expected %b", ctrl, 18'b0);
        end
        @(posedge clk); #1;
        tests_run++;
        if (illegal_op !== 1'b1) begin
            tests_failed++;
            $display("FAIL and_illegal: illegal_op=%b expected 1", illegal_op);
        end
        @(negedge clk);
        rst = 1'b1;
        opcode = 11'b10101011000;
        @(posedge clk); #1;
        rst = 1'b0;
`endif
    endtask

    task automatic test_illegal;
        apply(11'b00000000000, 9'h000);
        tests_run++;
        if (ctrl !== 18'b0 || illegal_op !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_comb: ctrl=%b ill=%b expected 0 0", ctrl, illegal_op);
        end
        @(posedge clk); #1;
        tests_run++;
        if (illegal_op !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_set: illegal_op=%b expected 1", illegal_op);
        end
        apply(11'b10101011000, 9'h000);
        @(posedge clk); #1;
        apply(11'b11111000010, 9'h010);
        @(posedge clk); #1;
        tests_run++;
        if (illegal_op !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_sticky: illegal_op=%b expected 1", illegal_op);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if (illegal_op !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_clear: illegal_op=%b expected 0", illegal_op);
        end
    endtask

    task automatic test_rst_gating;
        @(negedge clk);
        rst = 1'b1;
        opcode = 11'b11111000000;
        daddr9 = 9'h010;
        #1;
        tests_run++;
        if (ctrl !== 18'b0_1_0_0_0_0_0_0_0_0_0_0_0_0_1_010) begin
            tests_failed++;
            $display("FAIL stur_in_rst: ctrl=%b expected %b", ctrl, 18'b0_1_0_0_0_0_0_0_0_0_0_0_0_0_1_010);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (mem_write !== 1'b1 || alu_src !== 1'b1 || reg2loc !== 1'b0) begin
            tests_failed++;
            $display("FAIL stur_after_rst: mw=%b as=%b r2l=%b expected 1 1 0", mem_write, alu_src, reg2loc);
        end
        apply(11'b10010100000, 9'h000);
        rst = 1'b1;
        #1;
        tests_run++;
        if (ctrl !== 18'b0_0_0_0_0_0_0_0_1_0_1_0_0_0_0_000) begin
            tests_failed++;
            $display("FAIL bl_in_rst: ctrl=%b expected %b", ctrl, 18'b0_0_0_0_0_0_0_0_1_0_1_0_0_0_0_000);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 11'b10101011000;
        daddr9 = 9'h000;
        test_reset();
        test_arith();
        test_mem_offset();
        test_branch();
        test_shift();
        test_logic_ops();
        test_illegal();
        test_rst_gating();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded, expected completion");
        $fatal(1);
    end

endmodule
